// File: rtl/laser_bounce_if.sv
// Pixel-write, obstacle-query and run-control bundle between the bouncing-laser engine
// and its environment (VGA adapter, obstacle map and controller).
interface laser_bounce_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int CNT_W   = 8
);
  logic               start;
  logic               halt;
  logic               obstacle;
  logic [X_W-1:0]     obs_x;
  logic [Y_W-1:0]     obs_y;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] colour;
  logic               plot;
  logic               busy;
  logic [CNT_W-1:0]   bounce_count;

  modport master (
    input  start, halt, obstacle,
    output obs_x, obs_y, x, y, colour, plot, busy, bounce_count
  );

  modport slave (
    output start, halt, obstacle,
    input  obs_x, obs_y, x, y, colour, plot, busy, bounce_count
  );
endinterface

// File: rtl/laser_bounce_engine.sv
// One bouncing laser pixel: position/direction state, step timer and erase/move/check/draw FSM,
// reflecting off screen edges and off obstacles reported by an external map.
module laser_bounce_engine #(
  parameter int                 X_W       = 8,
  parameter int                 Y_W       = 7,
  parameter int                 X_MAX     = 159,
  parameter int                 Y_MAX     = 119,
  parameter int                 START_X   = 0,
  parameter int                 START_Y   = 0,
  parameter int                 TICKS     = 833333,
  parameter int                 TIMER_W   = 20,
  parameter int                 COLOR_W   = 3,
  parameter logic [COLOR_W-1:0] LASER_COL = 'b100,
  parameter logic [COLOR_W-1:0] BG_COL    = '0,
  parameter int                 CNT_W     = 8
) (
  input logic            clk,
  input logic            resetn,
  laser_bounce_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ERASE = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DRAW  = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [X_W-1:0]     XMAX_V   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]     YMAX_V   = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]     XSTART_V = X_W'(START_X);
  localparam logic [Y_W-1:0]     YSTART_V = Y_W'(START_Y);
  localparam logic [TIMER_W-1:0] TLAST_V  = TIMER_W'(TICKS - 1);

  logic [2:0]         state_q, state_d;
  logic [X_W-1:0]     xpos_q, xpos_d;
  logic [Y_W-1:0]     ypos_q, ypos_d;
  // Direction bits: 0 means +1, 1 means -1, so the reset value is +1/+1.
  logic               xneg_q, xneg_d;
  logic               yneg_q, yneg_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [X_W-1:0]     obs_x_q, obs_x_d;
  logic [Y_W-1:0]     obs_y_q, obs_y_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic               plot_q, plot_d;
  logic [CNT_W-1:0]   bounce_q, bounce_d;

  logic               flip_x, flip_y;
  logic               xneg_new, yneg_new;
  logic [X_W-1:0]     cand_x;
  logic [Y_W-1:0]     cand_y;
  logic               bump;

  // Edge pre-check and candidate. The "stay put" arm only matters for a zero-size axis,
  // where the flipped direction would still point off-screen.
  always_comb begin
    flip_x   = (!xneg_q && (xpos_q == XMAX_V)) || (xneg_q && (xpos_q == '0));
    flip_y   = (!yneg_q && (ypos_q == YMAX_V)) || (yneg_q && (ypos_q == '0));
    xneg_new = xneg_q ^ flip_x;
    yneg_new = yneg_q ^ flip_y;

    cand_x = xpos_q;
    if (!xneg_new && (xpos_q != XMAX_V)) cand_x = xpos_q + X_W'(1);
    else if (xneg_new && (xpos_q != '0)) cand_x = xpos_q - X_W'(1);

    cand_y = ypos_q;
    if (!yneg_new && (ypos_q != YMAX_V)) cand_y = ypos_q + Y_W'(1);
    else if (yneg_new && (ypos_q != '0)) cand_y = ypos_q - Y_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    xneg_d   = xneg_q;
    yneg_d   = yneg_q;
    timer_d  = timer_q;
    obs_x_d  = obs_x_q;
    obs_y_d  = obs_y_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    bump     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_DRAW;
          xpos_d   = XSTART_V;
          ypos_d   = YSTART_V;
          xneg_d   = 1'b0;
          yneg_d   = 1'b0;
          timer_d  = '0;
          plot_d   = 1'b1;
          x_d      = XSTART_V;
          y_d      = YSTART_V;
          colour_d = LASER_COL;
        end
      end

      S_WAIT: begin
        if (timer_q == TLAST_V) begin
          state_d  = bus.halt ? S_HALT : S_ERASE;
          plot_d   = 1'b1;
          x_d      = xpos_q;
          y_d      = ypos_q;
          colour_d = BG_COL;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      S_ERASE: state_d = S_MOVE;

      S_MOVE: begin
        state_d = S_CHECK;
        xneg_d  = xneg_new;
        yneg_d  = yneg_new;
        obs_x_d = cand_x;
        obs_y_d = cand_y;
        bump    = flip_x | flip_y;
      end

      S_CHECK: begin
        state_d = S_DRAW;
        if (bus.obstacle) begin
          xneg_d = ~xneg_q;
          yneg_d = ~yneg_q;
          bump   = 1'b1;
        end else begin
          xpos_d = obs_x_q;
          ypos_d = obs_y_q;
        end
        // Pixel registers take the post-check position so DRAW shows where we ended up.
        plot_d   = 1'b1;
        x_d      = xpos_d;
        y_d      = ypos_d;
        colour_d = LASER_COL;
      end

      S_DRAW: begin
        state_d = S_WAIT;
        timer_d = '0;
      end

      S_HALT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bounce_d = bounce_q;
    if ((state_q == S_IDLE) && bus.start) bounce_d = '0;
    else if (bump && !(&bounce_q))        bounce_d = bounce_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      xpos_q   <= XSTART_V;
      ypos_q   <= YSTART_V;
      xneg_q   <= 1'b0;
      yneg_q   <= 1'b0;
      timer_q  <= '0;
      obs_x_q  <= '0;
      obs_y_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      xneg_q   <= xneg_d;
      yneg_q   <= yneg_d;
      timer_q  <= timer_d;
      obs_x_q  <= obs_x_d;
      obs_y_q  <= obs_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      bounce_q <= bounce_d;
    end
  end

  assign bus.obs_x        = obs_x_q;
  assign bus.obs_y        = obs_y_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.colour       = colour_q;
  assign bus.plot         = plot_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.bounce_count = bounce_q;

endmodule

// File: tb/tb_laser_bounce_engine.sv
// Directed bench for laser_bounce_engine: a 4x3 field (main) and a 3x3 field (corner case),
// both with TICKS = 2, checked against hand-computed draw/erase tables.
module tb_laser_bounce_engine;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic obs_en = 1'b0;
  always #5 clk = ~clk;

  laser_bounce_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .CNT_W(8)) a_if ();
  laser_bounce_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .CNT_W(8)) b_if ();

  laser_bounce_engine #(
    .X_MAX(3), .Y_MAX(2), .START_X(0), .START_Y(0), .TICKS(2), .TIMER_W(4)
  ) u_dut (
    .clk(clk), .resetn(resetn), .bus(a_if.master)
  );

  laser_bounce_engine #(
    .X_MAX(2), .Y_MAX(2), .START_X(0), .START_Y(0), .TICKS(2), .TIMER_W(4)
  ) u_corner (
    .clk(clk), .resetn(resetn), .bus(b_if.master)
  );

  // Obstacle map for the main instance: a single blocked cell at (2,2) when enabled.
  always_comb a_if.obstacle = obs_en && (a_if.obs_x == 8'd2) && (a_if.obs_y == 7'd2);
  assign b_if.obstacle = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sel;
    int ex;
    int ey;
    int eb;
  } step_t;
  step_t tbl [16];

  int p_x, p_y, p_c, p_b, p_cyc;
  int prev_x, prev_y, prev_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for the next plot strobe on the selected instance.
  task automatic next_plot(input int sel, input int budget);
    bit found = 1'b0;
    p_x = -1; p_y = -1; p_c = -1; p_b = -1; p_cyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if ((sel != 0) ? b_if.plot : a_if.plot) begin
        found = 1'b1;
        p_x   = int'((sel != 0) ? b_if.x : a_if.x);
        p_y   = int'((sel != 0) ? b_if.y : a_if.y);
        p_c   = int'((sel != 0) ? b_if.colour : a_if.colour);
        p_b   = int'((sel != 0) ? b_if.bounce_count : a_if.bounce_count);
        p_cyc = cyc;
      end
    end
    chk("plot_seen", int'(found), 1);
  endtask

  task automatic run_steps(input int first, input int last);
    int ce;
    for (int i = first; i <= last; i++) begin
      next_plot(tbl[i].sel, 20);
      chk("erase_col", p_c, 0);
      chk("erase_x", p_x, prev_x);
      chk("erase_y", p_y, prev_y);
      ce = p_cyc;
      next_plot(tbl[i].sel, 20);
      chk("draw_col", p_c, 4);
      chk("draw_x", p_x, tbl[i].ex);
      chk("draw_y", p_y, tbl[i].ey);
      chk("bounce", p_b, tbl[i].eb);
      chk("erase_to_draw", p_cyc - ce, 3);
      chk("period", p_cyc - prev_cyc, 6);
      $display("step %0d inst %0d: draw (%0d,%0d) bounce %0d at cycle %0d",
               i, tbl[i].sel, p_x, p_y, p_b, p_cyc);
      prev_x = p_x; prev_y = p_y; prev_cyc = p_cyc;
    end
  endtask

  task automatic check_first_draw(input int sel, input string tag);
    chk({tag, "_plot"},   int'((sel != 0) ? b_if.plot : a_if.plot), 1);
    chk({tag, "_x"},      int'((sel != 0) ? b_if.x : a_if.x), 0);
    chk({tag, "_y"},      int'((sel != 0) ? b_if.y : a_if.y), 0);
    chk({tag, "_col"},    int'((sel != 0) ? b_if.colour : a_if.colour), 4);
    chk({tag, "_busy"},   int'((sel != 0) ? b_if.busy : a_if.busy), 1);
    chk({tag, "_bounce"}, int'((sel != 0) ? b_if.bounce_count : a_if.bounce_count), 0);
    $display("%s: first draw at (0,0) cycle %0d", tag, cyc);
    prev_x = 0; prev_y = 0; prev_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hcyc;
    // corner field 3x3: (2,2) reflects on both axes as a single bounce
    tbl[0]  = '{1, 1, 1, 0};
    tbl[1]  = '{1, 2, 2, 0};
    tbl[2]  = '{1, 1, 1, 1};
    tbl[3]  = '{1, 0, 0, 1};
    // main field 4x3 free run
    tbl[4]  = '{0, 1, 1, 0};
    tbl[5]  = '{0, 2, 2, 0};
    tbl[6]  = '{0, 3, 1, 1};
    tbl[7]  = '{0, 2, 0, 2};
    tbl[8]  = '{0, 1, 1, 3};
    tbl[9]  = '{0, 0, 2, 3};
    tbl[10] = '{0, 1, 1, 4};
    // obstacle at (2,2): redraw in place, then head back
    tbl[11] = '{0, 1, 1, 0};
    tbl[12] = '{0, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 1};
    tbl[14] = '{0, 1, 1, 2};
    // after mid-run reset and restart
    tbl[15] = '{0, 1, 1, 0};

    a_if.start = 1'b0; a_if.halt = 1'b0;
    b_if.start = 1'b0; b_if.halt = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot",   int'(a_if.plot), 0);
    chk("rst_x",      int'(a_if.x), 0);
    chk("rst_y",      int'(a_if.y), 0);
    chk("rst_col",    int'(a_if.colour), 0);
    chk("rst_busy",   int'(a_if.busy), 0);
    chk("rst_bounce", int'(a_if.bounce_count), 0);
    resetn = 1'b1;

    // corner instance
    @(posedge clk); #1;
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    check_first_draw(1, "corner_start");
    run_steps(0, 3);

    // main instance: start and free run
    @(posedge clk); #1;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    check_first_draw(0, "main_start");
    run_steps(4, 10);

    // halt at the next WAIT expiry: erase at (1,1) then idle
    a_if.halt = 1'b1;
    next_plot(0, 20);
    hcyc = p_cyc;
    chk("halt_col", p_c, 0);
    chk("halt_x", p_x, 1);
    chk("halt_y", p_y, 1);
    chk("halt_delay", hcyc - prev_cyc, 3);
    @(posedge clk); #1;
    a_if.halt = 1'b0;
    chk("halt_plot_off", int'(a_if.plot), 0);
    chk("halt_busy", int'(a_if.busy), 0);
    $display("halt: erase (%0d,%0d) at cycle %0d, busy now %0d", p_x, p_y, hcyc, a_if.busy);

    // restart; start stays high while busy and must be ignored
    a_if.start = 1'b1;
    @(posedge clk); #1;
    check_first_draw(0, "restart");
    obs_en = 1'b1;
    run_steps(11, 14);
    a_if.start = 1'b0;
    obs_en = 1'b0;

    // asynchronous reset while in MOVE
    next_plot(0, 20);
    chk("pre_rst_erase_col", p_c, 0);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("midrst_plot",   int'(a_if.plot), 0);
    chk("midrst_x",      int'(a_if.x), 0);
    chk("midrst_y",      int'(a_if.y), 0);
    chk("midrst_col",    int'(a_if.colour), 0);
    chk("midrst_busy",   int'(a_if.busy), 0);
    chk("midrst_bounce", int'(a_if.bounce_count), 0);
    chk("midrst_obs_x",  int'(a_if.obs_x), 0);
    $display("mid-run reset applied at t=%0t", $time);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", int'(a_if.busy), 0);
    chk("idle_plot", int'(a_if.plot), 0);

    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    check_first_draw(0, "post_reset_start");
    run_steps(15, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
